// File: rtl/divider_unit.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve at accept without iterating.
module divider_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       DIVop,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             div_valid,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_rdata,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_is_rem;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_ready;
    logic [WIDTH-1:0] r_rdata;
    logic             r_busy;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_special;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_result;

    always_comb begin
        w_signed   = ~DIVop[0];
        w_a_neg    = w_signed & dividend[WIDTH-1];
        w_b_neg    = w_signed & divisor[WIDTH-1];
        w_a_mag    = w_a_neg ? -dividend : dividend;
        w_b_mag    = w_b_neg ? -divisor : divisor;
        w_div_zero = (divisor == '0);
        w_ovf      = w_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);

        w_special = '0;
        if (w_div_zero)
            w_special = DIVop[1] ? dividend : '1;
        else if (w_ovf)
            w_special = DIVop[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};

        // Shifted remainder needs WIDTH+1 bits; once the trial succeeds the
        // difference is below the divisor, so a WIDTH-bit subtract is exact.
        w_shift  = {r_rem, r_quo[WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_div});
        w_rem_nx = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
        w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

        if (r_is_rem)
            w_result = r_r_neg ? -w_rem_nx : w_rem_nx;
        else
            w_result = r_q_neg ? -w_quo_nx : w_quo_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_is_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_valid) begin
                        r_is_rem <= DIVop[1];
                        r_busy   <= 1'b1;
                        if (w_div_zero || w_ovf) begin
                            r_rdata <= w_special;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_div   <= w_b_mag;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - CW'(1);
                    // Final iteration's result is registered directly so the
                    // done pulse coincides with entry to DONE.
                    if (r_cnt == '0) begin
                        r_rdata <= w_result;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_ready = r_ready;
    assign div_rdata = r_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed RV32M cases, reset abort,
// back-to-back issue and a few randomised operations against a behavioural model.
`timescale 1ns/1ps
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  DIVop = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic [31:0] div_rdata;
    logic        busy;

    divider_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .DIVop     (DIVop),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_rdata (div_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned lat;
        int unsigned t0;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Output monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (div_ready) begin
                check("pulse_width", {31'b0, prev_ready}, 32'd0);
                check("busy_with_ready", {31'b0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    check("spurious_ready", {31'b0, div_ready}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_data"}, div_rdata, e.data);
                    check({e.tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
                end
            end
            prev_ready = div_ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic wait_idle();
        int unsigned g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_done();
        int unsigned g = 0;
        while ((sb.size() != 0 || busy) && g < 80) begin
            @(negedge clk);
            g++;
        end
        if (g >= 80) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int unsigned lat, input bit scramble);
        wait_idle();
        DIVop     = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        sb.push_back('{exp, lat, cyc, tag});
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        if (scramble) begin
            DIVop    = 2'($urandom);
            dividend = $urandom;
            divisor  = $urandom;
            if (lat == 33) begin
                repeat (3) begin
                    @(negedge clk);
                    div_valid = ~div_valid;
                end
                @(negedge clk);
                div_valid = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned g;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, div_ready}, 32'd0);
        check("reset_rdata", div_rdata, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        issue("divu_max", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 1'b1);
        issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        issue("remu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 33, 1'b0);
        issue("div_by0", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        issue("remu_by0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 1'b0);
        issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        issue("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        issue("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14, 33, 1'b0);

        // Reset mid-operation: the aborted op is never pushed, so any later
        // pulse from it is reported as spurious.
        wait_idle();
        DIVop     = 2'b00;
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_ready", {31'b0, div_ready}, 32'd0);
        check("midrst_rdata", div_rdata, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        issue("divu_after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0);

        // Back-to-back: second op is presented while DONE and accepted in IDLE.
        wait_idle();
        DIVop     = 2'b00;
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_valid = 1'b1;
        sb.push_back('{32'd14, 33, cyc, "b2b_div"});
        @(posedge clk);
        #1;
        DIVop    = 2'b01;
        dividend = $urandom;
        divisor  = $urandom;
        repeat (4) begin
            @(negedge clk);
            div_valid = ~div_valid;
        end
        div_valid = 1'b1;
        @(negedge clk);
        g = 0;
        while (!div_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        DIVop    = 2'b10;
        dividend = 32'd100;
        divisor  = 32'd7;
        sb.push_back('{32'd2, 33, cyc + 1, "b2b_rem"});
        @(posedge clk);
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        wait_done();

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 5) b = 32'd0;
            issue($sformatf("rand%0d", i), op, a, b, model(op, a, b), model_lat(op, a, b), 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
Multicycle radix-2 restoring divider executing RV32M DIV/DIVU/REM/REMU. It sits directly downstream of the M-extension decoder: it consumes DIVop and div_valid, takes its operands from the register-file read latches, and returns a single 32-bit result to the multicycle control FSM with a one-cycle done pulse. It implements the RISC-V divide-by-zero and signed-overflow results without trapping.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
DIVop  input  2  operation: 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU (funct3[1:0])
dividend  input  WIDTH  rs1 value
divisor  input  WIDTH  rs2 value
div_valid  input  1  start request; held high by the control FSM until div_ready
div_ready  output  1  one-cycle pulse: div_rdata is valid
div_rdata  output  WIDTH  quotient or remainder
busy  output  1  high while in CALC or DONE

Behaviour:
- Reset (async, resetn=0): state=IDLE; div_ready=0, div_rdata=0, busy=0; all internal registers cleared. This applies mid-operation, and the operation in flight is discarded.
- States: IDLE, CALC, DONE.
- IDLE: if div_valid=1, capture DIVop, dividend and divisor at that edge (cycle T0).
  - If divisor=0, or the op is signed with dividend=0x80000000 and divisor=0xFFFFFFFF, load the special result and go to DONE.
  - Otherwise go to CALC with counter=WIDTH-1.
- Operand prep at accept, signed ops: magnitudes |a| and |b|. Record q_neg=a[31]^b[31] and r_neg=a[31]. Unsigned ops: q_neg=r_neg=0.
- CALC, one iteration per cycle:
  - {rem,quo} shifted left 1, with the quotient bit shifted in from the dividend MSB.
  - Trial subtract rem-|b| over WIDTH+1 bits. If the result is non-negative, keep it and set the quotient bit to 1.
  - counter decrements. At counter=0, go to DONE.
- DONE: div_ready=1 for exactly one cycle, busy=1, then go to IDLE.
  - div_rdata gets the quotient (negated if q_neg) for DIV/DIVU, or the remainder (negated if r_neg) for REM/REMU.
  - div_rdata is registered and holds until the next DONE.
- Latency from the accept edge to the div_ready cycle:
  - normal: WIDTH+1 cycles (33), so div_ready is high in cycle T33.
  - special cases: 1 cycle (T1).
- Special results:
  - divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend unchanged.
  - signed overflow: DIV gives 0x80000000; REM gives 0.
- Operand and DIVop changes after accept are ignored. Deasserting div_valid mid-operation does not abort; the operation completes and pulses div_ready.
- div_valid=1 in IDLE on the cycle after DONE starts a new operation. The control FSM is responsible for deasserting div_valid after div_ready; back-to-back ops are legal.
- div_valid is ignored while busy=1.

Test Plan:
- DIVU 0xFFFFFFFF/0x00000002 -> div_rdata=0x7FFFFFFF, div_ready exactly 33 cycles after accept, single-cycle pulse.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 0x00000001; REMU 7/2 -> 1.
- Divisor 0, dividend 0x12345678: DIV -> 0xFFFFFFFF, REMU -> 0x12345678, each with div_ready 1 cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIVU same operands -> 0x00000000 via the normal 33-cycle path.
- Start DIV 100/7, pull resetn low at cycle 10, release, then start DIVU 100/7 -> no div_ready before reset, outputs 0 during reset, second result 14 at 33 cycles.
- Back-to-back: DIV 100/7 then REM 100/7 issued in the IDLE cycle after the first div_ready -> results 14 then 2. Operand changes during CALC are ignored and div_valid toggling while busy has no effect.
